// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from four requesters into a single UART
// transmitter, spacing start pulses a fixed number of clock cycles apart.
module uart_tx_scheduler #(
   parameter logic [31:0] CLOCK_FREQ   = 32'd50_000_000,
   parameter logic [31:0] UART_BAUD    = 32'd115200,
   parameter logic [31:0] FRAME_CYCLES = (CLOCK_FREQ / UART_BAUD) * 32'd11,
   parameter logic [31:0] GAP_CYCLES   = 32'd0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_enable,
   output logic [1:0]  grant_id,
   output logic        busy
);

   typedef enum logic [1:0] {
      HOLDOFF,
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   // One ISSUE cycle and one IDLE cycle sit inside each period, so WAIT covers
   // the remaining PERIOD-2 cycles (counter runs PERIOD-3 down to 0).
   localparam logic [31:0] PERIOD    = FRAME_CYCLES + GAP_CYCLES;
   localparam logic [31:0] WAIT_LOAD = PERIOD - 32'd3;

   state_t      state, state_nxt;
   logic [31:0] count, count_nxt;
   logic [1:0]  ptr, ptr_nxt;
   logic [7:0]  data_nxt;
   logic [1:0]  grant_nxt;
   logic        enable_nxt;
   logic [3:0]  ready_nxt;
   logic        busy_nxt;

   logic        found;
   logic [1:0]  sel;

   always_comb begin
      found = 1'b0;
      sel   = ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!found && req_valid[ptr + 2'(i)]) begin
            found = 1'b1;
            sel   = ptr + 2'(i);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      ptr_nxt    = ptr;
      data_nxt   = uart_tx_data;
      grant_nxt  = grant_id;
      enable_nxt = 1'b0;
      ready_nxt  = '0;
      case (state)
         HOLDOFF: begin
            if (count <= 32'd1) state_nxt = IDLE;
            else                count_nxt = count - 32'd1;
         end
         IDLE: begin
            if (found) begin
               data_nxt   = req_data[{sel, 3'b000} +: 8];
               grant_nxt  = sel;
               enable_nxt = 1'b1;
               ready_nxt  = 4'(1) << sel;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            ptr_nxt   = grant_id + 2'd1;
            count_nxt = WAIT_LOAD;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (count == '0) state_nxt = IDLE;
            else             count_nxt = count - 32'd1;
         end
         default: state_nxt = HOLDOFF;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= HOLDOFF;
         count          <= FRAME_CYCLES;
         ptr            <= '0;
         uart_tx_data   <= '0;
         grant_id       <= '0;
         uart_tx_enable <= 1'b0;
         req_ready      <= '0;
         busy           <= 1'b1;
      end else begin
         state          <= state_nxt;
         count          <= count_nxt;
         ptr            <= ptr_nxt;
         uart_tx_data   <= data_nxt;
         grant_id       <= grant_nxt;
         uart_tx_enable <= enable_nxt;
         req_ready      <= ready_nxt;
         busy           <= busy_nxt;
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 32'd50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 32'd115200, line baud rate.
REQ-003 SHALL have parameter FRAME_CYCLES, default (CLOCK_FREQ/UART_BAUD)*11, clock cycles reserved per transmitted byte.
REQ-004 SHALL have parameter GAP_CYCLES, default 32'd0, extra idle cycles between frames; FRAME_CYCLES+GAP_CYCLES >= 3.
REQ-005 SHALL have port clk_in, input, 1, single clock, all logic on posedge.
REQ-006 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 4, requester i has a byte pending.
REQ-008 SHALL have port req_data, input, 32, byte of requester i on bits [8i+7:8i].
REQ-009 SHALL have port req_ready, output, 4, one-cycle accept pulse to requester i.
REQ-010 SHALL have port uart_tx_data, output, 8, byte to the downstream UART transmitter.
REQ-011 SHALL have port uart_tx_enable, output, 1, one-cycle start pulse to the transmitter.
REQ-012 SHALL have port grant_id, output, 2, index of the last granted requester.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states HOLDOFF, IDLE, ISSUE, WAIT; all outputs registered.
REQ-015 In IDLE with any req_valid high: round-robin select, search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); capture that requester's byte into uart_tx_data, set grant_id; next state ISSUE.
REQ-016 In IDLE with req_valid == 0: remain IDLE; uart_tx_data, grant_id hold value.
REQ-017 ISSUE lasts exactly one cycle: uart_tx_enable = 1 and req_ready[grant_id] = 1, all other req_ready bits 0; ptr <= grant_id+1 (mod 4, 2-bit wrap); next state WAIT.
REQ-018 uart_tx_enable and req_ready SHALL be 0 in every state other than ISSUE.
REQ-019 WAIT SHALL run a 32-bit down-counter so that, with continuous requests, consecutive uart_tx_enable pulses are exactly FRAME_CYCLES+GAP_CYCLES cycles apart; then IDLE.
REQ-020 req_valid changes during HOLDOFF, ISSUE or WAIT SHALL have no effect; arbitration is evaluated only in IDLE.
REQ-021 A requester SHALL hold req_valid and req_data stable until its req_ready pulse; dropping req_valid before the grant withdraws the request without side effects.
REQ-022 A requester keeping req_valid high after req_ready is treated as presenting a new byte at the next IDLE.
REQ-023 Simultaneous requests: exactly one grant per frame; no requester waits more than 3 frames while continuously valid.
REQ-024 HOLDOFF SHALL count FRAME_CYCLES cycles then enter IDLE, so a frame in progress in the un-reset transmitter completes before a new enable.

Reset
REQ-025 rst_in high SHALL immediately force: state HOLDOFF, counter = FRAME_CYCLES, ptr = 0, uart_tx_data = 8'h00, grant_id = 0, uart_tx_enable = 0, req_ready = 0, busy = 1.
REQ-026 Reset asserted mid-ISSUE or mid-WAIT SHALL abandon the frame silently; the aborted requester receives no further req_ready for that byte unless it re-requests.
REQ-027 After rst_in deasserts, the first uart_tx_enable SHALL occur no earlier than FRAME_CYCLES+1 cycles later.

Verification (FRAME_CYCLES=20, GAP_CYCLES=2)
REQ-028 Reset release, req_valid=4'b0000 -> busy=1 for 20 cycles, then busy=0, no enable.
REQ-029 After HOLDOFF, req_valid=4'b0100, byte2=8'hA5 -> next cycle ISSUE: uart_tx_data=8'hA5, enable=1, req_ready=4'b0100, grant_id=2 for one cycle.
REQ-030 All four valid continuously, bytes 8'h10/11/12/13 -> grants 0,1,2,3,0 in order, enable pulses exactly 22 cycles apart.
REQ-031 ptr=3 after grant 2, req_valid=4'b1001 -> requester 3 granted before 0.
REQ-032 req_valid[1] raised then dropped during WAIT, others 0 -> no grant, state returns IDLE and stays.
REQ-033 rst_in pulsed 5 cycles into WAIT -> outputs at reset values immediately, next enable no earlier than 21 cycles after deassertion.
